// File: rtl/code_mem_arbiter_if.sv
// Request/response and code-memory signals shared by the fetch unit, loader, arbiter and memory.
// The slave modport is the arbiter; master is the requester/memory side.
interface code_mem_arbiter_if;
  logic        iFetchReq;
  logic [63:0] iFetchAddr;
  logic        oFetchGnt;
  logic        oFetchValid;
  logic [31:0] oFetchData;
  logic        oFetchErr;

  logic        iLdReq;
  logic        iLdWe;
  logic [3:0]  iLdBe;
  logic [63:0] iLdAddr;
  logic [31:0] iLdWData;
  logic        iLdLock;
  logic        oLdGnt;
  logic        oLdValid;
  logic [31:0] oLdRData;
  logic        oLdErr;

  logic        oMemRe;
  logic        oMemWe;
  logic [3:0]  oMemBe;
  logic [63:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [31:0] iMemRData;

  logic        oBusy;

  modport slave (
    input  iFetchReq, iFetchAddr,
    output oFetchGnt, oFetchValid, oFetchData, oFetchErr,
    input  iLdReq, iLdWe, iLdBe, iLdAddr, iLdWData, iLdLock,
    output oLdGnt, oLdValid, oLdRData, oLdErr,
    output oMemRe, oMemWe, oMemBe, oMemAddr, oMemWData,
    input  iMemRData,
    output oBusy
  );

  modport master (
    output iFetchReq, iFetchAddr,
    input  oFetchGnt, oFetchValid, oFetchData, oFetchErr,
    output iLdReq, iLdWe, iLdBe, iLdAddr, iLdWData, iLdLock,
    input  oLdGnt, oLdValid, oLdRData, oLdErr,
    input  oMemRe, oMemWe, oMemBe, oMemAddr, oMemWData,
    output iMemRData,
    input  oBusy
  );
endinterface

// File: rtl/code_mem_arbiter.sv
// Arbitrates fetch and loader access to the code memory; gnt one cycle after the request edge, valid one after gnt.
// Backpressure: requests are held until their gnt pulse; one access every two cycles at best.
module code_mem_arbiter #(
  parameter logic [63:0] BEGINNING_TEXT  = 64'h0000_0000_0040_0000,
  parameter logic [63:0] END_TEXT        = 64'h0000_0000_0040_3FFC,
  parameter int unsigned MAX_FETCH_BURST = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  code_mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [2:0] BURST_MAX = 3'(MAX_FETCH_BURST);

  logic [1:0]  state;
  logic [2:0]  starve_cnt;
  logic        cmd_ld;
  logic        cmd_we;
  logic        cmd_in_range;
  logic [3:0]  cmd_be;
  logic [63:0] cmd_addr;
  logic [31:0] cmd_wdata;

  // addr[1:0] never takes part in the range check
  function automatic logic in_text(input logic [63:0] addr);
    logic [63:0] word_addr;
    word_addr = addr & ~64'h3;
    return (word_addr >= BEGINNING_TEXT) && (word_addr <= END_TEXT);
  endfunction

  logic fetch_elig;
  logic ld_elig;
  logic pick_ld;
  logic pick_any;

  always_comb begin
    fetch_elig = bus.iFetchReq & ~bus.iLdLock;
    ld_elig    = bus.iLdReq;
    pick_ld    = ld_elig & (~fetch_elig | (starve_cnt == BURST_MAX));
    pick_any   = (state != ACCESS) & (fetch_elig | ld_elig);
  end

  logic in_access;
  logic in_resp;
  logic fetch_gnt;
  logic ld_gnt;
  logic rd_ok;

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP) & ~iRST;
  assign fetch_gnt = in_access & ~cmd_ld;
  assign ld_gnt    = in_access & cmd_ld;
  assign rd_ok     = cmd_in_range & ~cmd_we;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      cmd_ld       <= 1'b0;
      cmd_we       <= 1'b0;
      cmd_in_range <= 1'b0;
      cmd_be       <= '0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
    end else begin
      case (state)
        ACCESS:  state <= RESP;
        default: state <= pick_any ? ACCESS : IDLE;
      endcase

      if (pick_any) begin
        cmd_ld <= pick_ld;
        if (pick_ld) begin
          cmd_we       <= bus.iLdWe;
          cmd_be       <= bus.iLdBe;
          cmd_addr     <= bus.iLdAddr;
          cmd_wdata    <= bus.iLdWData;
          cmd_in_range <= in_text(bus.iLdAddr);
        end else begin
          cmd_we       <= 1'b0;
          cmd_be       <= 4'b1111;
          cmd_addr     <= bus.iFetchAddr;
          cmd_wdata    <= '0;
          cmd_in_range <= in_text(bus.iFetchAddr);
        end
      end

      // Counts fetch grants that overtook a waiting loader request
      if (!bus.iLdReq || ld_gnt) begin
        starve_cnt <= '0;
      end else if (fetch_gnt && (starve_cnt != BURST_MAX)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

  assign bus.oFetchGnt = fetch_gnt;
  assign bus.oLdGnt    = ld_gnt;

  assign bus.oMemRe    = in_access & cmd_in_range & ~cmd_we;
  assign bus.oMemWe    = in_access & cmd_in_range & cmd_we;
  assign bus.oMemBe    = cmd_be;
  assign bus.oMemAddr  = cmd_addr;
  assign bus.oMemWData = cmd_wdata;

  assign bus.oFetchValid = in_resp & ~cmd_ld;
  assign bus.oFetchErr   = in_resp & ~cmd_ld & ~cmd_in_range;
  assign bus.oFetchData  = (in_resp & ~cmd_ld & rd_ok) ? bus.iMemRData : 32'h0;

  assign bus.oLdValid = in_resp & cmd_ld;
  assign bus.oLdErr   = in_resp & cmd_ld & ~cmd_in_range;
  assign bus.oLdRData = (in_resp & cmd_ld & rd_ok) ? bus.iMemRData : 32'h0;

  assign bus.oBusy = (state != IDLE);
endmodule

// File: tb/tb_code_mem_arbiter.sv
// Bench for code_mem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_code_mem_arbiter;
  localparam logic [63:0] BEG   = 64'h0000_0000_0040_0000;
  localparam logic [63:0] ENDT  = 64'h0000_0000_0040_3FFC;
  localparam int          BURST = 4;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  code_mem_arbiter_if bus();

  code_mem_arbiter #(
    .BEGINNING_TEXT (BEG),
    .END_TEXT       (ENDT),
    .MAX_FETCH_BURST(BURST)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  typedef struct {
    logic        vld;
    logic        ld;
    logic        we;
    logic [3:0]  be;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  int tests;
  int fails;

  // Reference model: transaction in its grant cycle, transaction in its response cycle
  txn_t        acc;
  txn_t        resp;
  int          starve;
  logic [63:0] h_addr;
  logic [3:0]  h_be;

  logic [31:0] ref_mem [logic [61:0]];
  logic [31:0] dev_mem [logic [61:0]];

  function automatic txn_t none();
    txn_t t;
    t.vld = 1'b0; t.ld = 1'b0; t.we = 1'b0; t.be = 4'h0;
    t.addr = 64'h0; t.wdata = 32'h0; t.rdata = 32'h0;
    return t;
  endfunction

  function automatic logic in_text(input logic [63:0] a);
    return ((a & ~64'h3) >= BEG) && ((a & ~64'h3) <= ENDT);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a[63:2]) ? ref_mem[a[63:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [63:0] a);
    return dev_mem.exists(a[63:2]) ? dev_mem[a[63:2]] : 32'h0;
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 64'h0000_0000_0000_1000;
      1:       return ENDT + 64'($urandom_range(0, 3));
      2:       return ENDT + 64'd4;
      3:       return BEG - 64'd4;
      default: return BEG + 64'(4 * $urandom_range(0, 31)) + 64'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: advance model and memory device, then compare every output
  task automatic step();
    logic        d_re, d_we;
    logic [63:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wd;
    logic        f_el, l_el, fv, lv, rd_ok;
    txn_t        nacc;

    d_re = bus.oMemRe; d_we = bus.oMemWe; d_addr = bus.oMemAddr;
    d_be = bus.oMemBe; d_wd = bus.oMemWData;

    if (acc.vld && in_text(acc.addr)) begin
      if (acc.we) ref_mem[acc.addr[63:2]] = merge(ref_rd(acc.addr), acc.wdata, acc.be);
      else        acc.rdata = ref_rd(acc.addr);
    end

    nacc = none();
    if (!iRST && !acc.vld) begin
      f_el = bus.iFetchReq && !bus.iLdLock;
      l_el = bus.iLdReq;
      if (l_el && (!f_el || starve == BURST)) begin
        nacc.vld = 1'b1; nacc.ld = 1'b1; nacc.we = bus.iLdWe; nacc.be = bus.iLdBe;
        nacc.addr = bus.iLdAddr; nacc.wdata = bus.iLdWData;
      end else if (f_el) begin
        nacc.vld = 1'b1; nacc.be = 4'hF; nacc.addr = bus.iFetchAddr;
      end
    end

    if (iRST || !bus.iLdReq || (acc.vld && acc.ld)) starve = 0;
    else if (acc.vld && !acc.ld && starve < BURST) starve = starve + 1;

    resp = iRST ? none() : acc;
    acc  = nacc;
    if (iRST) begin
      h_addr = 64'h0; h_be = 4'h0;
    end else if (nacc.vld) begin
      h_addr = nacc.addr; h_be = nacc.be;
    end

    @(posedge iCLK);
    #1;
    if (d_we === 1'b1) dev_mem[d_addr[63:2]] = merge(dev_rd(d_addr), d_wd, d_be);
    bus.iMemRData = (d_re === 1'b1) ? dev_rd(d_addr) : $urandom;
    #1;

    fv    = resp.vld && !resp.ld;
    lv    = resp.vld && resp.ld;
    rd_ok = in_text(resp.addr) && !resp.we;
    chk("fetch_gnt",   64'(bus.oFetchGnt),   64'(acc.vld && !acc.ld));
    chk("ld_gnt",      64'(bus.oLdGnt),      64'(acc.vld && acc.ld));
    chk("mem_re",      64'(bus.oMemRe),      64'(acc.vld && in_text(acc.addr) && !acc.we));
    chk("mem_we",      64'(bus.oMemWe),      64'(acc.vld && in_text(acc.addr) && acc.we));
    chk("mem_addr",    bus.oMemAddr,         h_addr);
    chk("mem_be",      64'(bus.oMemBe),      64'(h_be));
    if (acc.vld && acc.we) chk("mem_wdata", 64'(bus.oMemWData), 64'(acc.wdata));
    chk("fetch_valid", 64'(bus.oFetchValid), 64'(fv));
    chk("fetch_err",   64'(bus.oFetchErr),   64'(fv && !in_text(resp.addr)));
    if (fv) chk("fetch_data", 64'(bus.oFetchData), 64'(rd_ok ? resp.rdata : 32'h0));
    chk("ld_valid",    64'(bus.oLdValid),    64'(lv));
    chk("ld_err",      64'(bus.oLdErr),      64'(lv && !in_text(resp.addr)));
    if (lv) chk("ld_rdata", 64'(bus.oLdRData), 64'(rd_ok ? resp.rdata : 32'h0));
    chk("busy",        64'(bus.oBusy),       64'(acc.vld || resp.vld));

    // requesters drop a request once it has been granted
    if (acc.vld && !acc.ld) bus.iFetchReq = 1'b0;
    if (acc.vld && acc.ld)  bus.iLdReq    = 1'b0;
  endtask

  initial begin
    int          cnt_a, cnt_b;
    logic [9:0]  fg, lg;
    logic [31:0] w;
    logic [61:0] k;

    tests = 0; fails = 0;
    iRST = 1'b1;
    bus.iFetchReq = 1'b0; bus.iFetchAddr = 64'h0;
    bus.iLdReq = 1'b0; bus.iLdWe = 1'b0; bus.iLdBe = 4'h0; bus.iLdAddr = 64'h0;
    bus.iLdWData = 32'h0; bus.iLdLock = 1'b0; bus.iMemRData = 32'h0;
    acc = none(); resp = none(); starve = 0; h_addr = 64'h0; h_be = 4'h0;

    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      k = BEG[63:2] + 62'(i);
      ref_mem[k] = w;
      dev_mem[k] = w;
    end
    k = 62'h10_0004;
    ref_mem[k] = 32'h8B02_0020;
    dev_mem[k] = 32'h8B02_0020;

    // reset state
    step(); step();
    chk("rst_busy",  64'(bus.oBusy), 64'h0);
    chk("rst_addr",  bus.oMemAddr,   64'h0);
    chk("rst_fdata", 64'(bus.oFetchData), 64'h0);
    iRST = 1'b0;
    step();

    // single fetch read
    bus.iFetchReq = 1'b1; bus.iFetchAddr = 64'h0000_0000_0040_0010;
    step();
    chk("t019_gnt",  64'(bus.oFetchGnt), 64'h1);
    chk("t019_re",   64'(bus.oMemRe),    64'h1);
    chk("t019_addr", bus.oMemAddr,       64'h0000_0000_0040_0010);
    step();
    chk("t019_valid", 64'(bus.oFetchValid), 64'h1);
    chk("t019_data",  64'(bus.oFetchData),  64'h8B02_0020);
    step();

    // loader partial write
    bus.iLdReq = 1'b1; bus.iLdWe = 1'b1; bus.iLdBe = 4'b0011;
    bus.iLdAddr = 64'h0000_0000_0040_0004; bus.iLdWData = 32'hDEAD_BEEF;
    cnt_a = 0; cnt_b = 0;
    repeat (4) begin
      step();
      if (bus.oMemWe) begin
        cnt_a++;
        chk("t020_be", 64'(bus.oMemBe), 64'b0011);
      end
      if (bus.oLdValid) begin
        cnt_b++;
        chk("t020_err",   64'(bus.oLdErr),   64'h0);
        chk("t020_rdata", 64'(bus.oLdRData), 64'h0);
      end
    end
    chk("t020_we_cycles",    64'(cnt_a), 64'd1);
    chk("t020_valid_cycles", 64'(cnt_b), 64'd1);
    bus.iLdWe = 1'b0;

    // out-of-range fetch
    bus.iFetchReq = 1'b1; bus.iFetchAddr = 64'h0000_0000_0000_1000;
    cnt_a = 0; cnt_b = 0;
    repeat (3) begin
      step();
      if (bus.oMemRe) cnt_a++;
      if (bus.oFetchValid) begin
        cnt_b++;
        chk("t022_err",  64'(bus.oFetchErr),  64'h1);
        chk("t022_data", 64'(bus.oFetchData), 64'h0);
      end
    end
    chk("t022_re_cycles",    64'(cnt_a), 64'd0);
    chk("t022_valid_cycles", 64'(cnt_b), 64'd1);

    // fetch burst limit while the loader waits
    bus.iFetchReq = 1'b1; bus.iFetchAddr = BEG;
    bus.iLdReq = 1'b1; bus.iLdAddr = BEG + 64'd8;
    fg = '0; lg = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      fg = {fg[8:0], bus.oFetchGnt};
      lg = {lg[8:0], bus.oLdGnt};
      if (!bus.iFetchReq) begin
        bus.iFetchReq = 1'b1;
        bus.iFetchAddr = bus.iFetchAddr + 64'd4;
      end
    end
    chk("t021_fetch_gnts", 64'(fg), 64'(10'b1010101000));
    chk("t021_ld_gnts",    64'(lg), 64'(10'b0000000010));
    repeat (3) step();

    // lock blocks fetch until released
    bus.iLdLock = 1'b1;
    bus.iFetchReq = 1'b1; bus.iFetchAddr = BEG + 64'h20;
    bus.iLdReq = 1'b1; bus.iLdAddr = BEG + 64'h24;
    step();
    chk("t023_ld_gnt1",    64'(bus.oLdGnt),    64'h1);
    chk("t023_fetch_gnt1", 64'(bus.oFetchGnt), 64'h0);
    bus.iLdReq = 1'b1;
    step(); step();
    chk("t023_ld_gnt2",    64'(bus.oLdGnt),    64'h1);
    chk("t023_fetch_gnt2", 64'(bus.oFetchGnt), 64'h0);
    bus.iLdLock = 1'b0;
    step(); step();
    chk("t023_fetch_unlocked", 64'(bus.oFetchGnt), 64'h1);
    repeat (2) step();

    // reset during the response cycle, loader request held across release
    bus.iFetchReq = 1'b1; bus.iFetchAddr = BEG + 64'h10;
    step(); step();
    iRST = 1'b1;
    bus.iLdReq = 1'b1; bus.iLdWe = 1'b0; bus.iLdAddr = BEG + 64'h4;
    #1;
    chk("t024_valid_in_rst", 64'(bus.oFetchValid), 64'h0);
    step();
    chk("t024_busy",  64'(bus.oBusy),       64'h0);
    chk("t024_valid", 64'(bus.oFetchValid), 64'h0);
    chk("t024_addr",  bus.oMemAddr,         64'h0);
    chk("t024_data",  64'(bus.oFetchData),  64'h0);
    iRST = 1'b0;
    step();
    chk("t018_ld_gnt", 64'(bus.oLdGnt), 64'h1);
    repeat (2) step();

    // random traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      iRST = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) bus.iLdLock = ~bus.iLdLock;
      if (!bus.iFetchReq && $urandom_range(0, 2) != 0) begin
        bus.iFetchReq = 1'b1; bus.iFetchAddr = rand_addr();
      end
      if (!bus.iLdReq && $urandom_range(0, 3) == 0) begin
        bus.iLdReq = 1'b1; bus.iLdWe = 1'($urandom); bus.iLdBe = 4'($urandom);
        bus.iLdAddr = rand_addr(); bus.iLdWData = $urandom;
      end
      step();
    end
    iRST = 1'b0; bus.iLdLock = 1'b0;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/code_mem_arbiter.md
CODE_MEM_ARBITER -- requirements
Module: code_mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BEGINNING_TEXT, 64'h0000_0000_0040_0000, first valid code byte address.
- END_TEXT, 64'h0000_0000_0040_3FFC, last valid code word address.
- MAX_FETCH_BURST, 4, number of consecutive fetch grants allowed while a loader request waits.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- iCLK, in, 1, single clock; all state updates on the rising edge.
- iRST, in, 1, reset; synchronous, active-high.
- iFetchReq, in, 1, fetch request; held until oFetchGnt.
- iFetchAddr, in, 64, fetch byte address.
- oFetchGnt, out, 1, one-cycle pulse: fetch command issued.
- oFetchValid, out, 1, one-cycle pulse: fetch response present.
- oFetchData, out, 32, fetched instruction word.
- oFetchErr, out, 1, fetch address outside the text range; qualified by oFetchValid.
- iLdReq, in, 1, loader request; held until oLdGnt.
- iLdWe, in, 1, loader write (1) or read (0).
- iLdBe, in, 4, loader byte enables.
- iLdAddr, in, 64, loader byte address.
- iLdWData, in, 32, loader write data.
- iLdLock, in, 1, blocks fetch grants while high.
- oLdGnt, out, 1, one-cycle pulse: loader command issued.
- oLdValid, out, 1, one-cycle pulse: loader response/ack.
- oLdRData, out, 32, loader read data.
- oLdErr, out, 1, loader address out of range; qualified by oLdValid.
- oMemRe, out, 1, code memory read enable.
- oMemWe, out, 1, code memory write enable.
- oMemBe, out, 4, code memory byte enables.
- oMemAddr, out, 64, code memory byte address.
- oMemWData, out, 32, code memory write data.
- iMemRData, in, 32, memory read data; valid one cycle after oMemRe.
- oBusy, out, 1, high whenever the state is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-004 In IDLE or RESP, at the clock edge, if any eligible request exists, the arbiter SHALL latch the winner's address, write enable, byte enables and data into command registers and go to ACCESS; otherwise it SHALL go to IDLE.
REQ-005 ACCESS SHALL last exactly one cycle. During it, the winner's Gnt is high and oMemAddr/oMemBe/oMemWData are driven from the command registers.
- In range: oMemRe = ~we and oMemWe = we, both for this cycle only.
- Out of range: oMemRe and oMemWe stay 0.
- ACCESS always goes to RESP.
REQ-006 RESP SHALL last exactly one cycle. The winner's Valid is high; Data/RData = iMemRData for an in-range read, else 32'h0; Err = out-of-range flag.
REQ-007 Latency SHALL be: request sampled at edge N, Gnt in cycle N+1, Valid in cycle N+2. Peak throughput is one access per 2 cycles.
REQ-008 "In range" SHALL mean BEGINNING_TEXT <= addr <= END_TEXT, using unsigned 64-bit compare; addr[1:0] is ignored.
REQ-009 Fetch requests SHALL always present oMemBe = 4'b1111 and are read-only.
REQ-010 A fetch request SHALL be eligible only when iLdLock = 0. A loader request is always eligible.
REQ-011 Priority: fetch wins over loader unless the starvation counter equals MAX_FETCH_BURST, in which case the loader wins.
REQ-012 The starvation counter (3 bits, saturating at MAX_FETCH_BURST) SHALL be updated as follows:
- increment on each fetch grant while iLdReq = 1;
- clear on a loader grant;
- clear in any cycle where iLdReq = 0.
REQ-013 A request whose Gnt pulse is in progress SHALL NOT be granted again in the following RESP-cycle arbitration; its requester is expected to drop or change it.
REQ-014 Command registers SHALL hold their values outside ACCESS. oMemRe and oMemWe SHALL be 0 in IDLE and RESP.
REQ-015 Gnt, Valid and Err outputs of the non-winning requester SHALL stay 0.

Reset
REQ-016 With iRST high at an edge, the following SHALL be set: state = IDLE, counter = 0, all Gnt/Valid/Err/oMemRe/oMemWe = 0, data and address outputs = 0, oBusy = 0.
REQ-017 Reset during ACCESS or RESP SHALL abort the transaction: no Valid is produced for it, and any write strobe ends at that edge.
REQ-018 Requests held across the reset release SHALL be arbitrated normally from the first edge with iRST low.

Verification
REQ-019 Fetch at 64'h0040_0010, memory returns 32'h8B02_0020 -> oFetchGnt in cycle 1, oMemRe = 1 with oMemAddr = 64'h0040_0010 in cycle 1, oFetchValid with oFetchData = 32'h8B02_0020 in cycle 2.
REQ-020 Loader write to 64'h0040_0004 with data 32'hDEAD_BEEF, be = 4'b0011 -> exactly one cycle of oMemWe = 1, oMemBe = 4'b0011; oLdValid = 1, oLdErr = 0, oLdRData = 0.
REQ-021 Continuous fetch requests with iLdReq held high -> 4 fetch grants, then 1 loader grant, with Gnt pulses every 2 cycles.
REQ-022 Fetch at 64'h0000_1000 -> no oMemRe; oFetchValid = 1, oFetchErr = 1, oFetchData = 0.
REQ-023 iLdLock = 1 with both requesters active -> only the loader is granted; after iLdLock drops, fetch is granted at the next arbitration.
REQ-024 iRST asserted in the RESP cycle of a read -> no oFetchValid, outputs are 0 at the next cycle, and oBusy = 0.
